// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared state encoding and default widths for pulse dividers and meters.
package pulse_meter_pkg;
   localparam int unsigned DEF_CNT_W      = 27;
   localparam int unsigned DEF_MAX_PERIOD = (1 << 27) - 1;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2
   } state_t;
endpackage

// File: rtl/pulse_sync_edge.sv
// pulse_sync_edge: multi-stage synchronizer for an asynchronous input plus rising-edge detector.
module pulse_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_edge
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sync_d;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync   <= '0;
         r_sync_d <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_sync_d <= r_sync[SYNC_STAGES-1];
      end
   end
   assign o_edge = r_sync[SYNC_STAGES-1] & ~r_sync_d;
endmodule

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures clk cycles between rising edges of a pulse input,
// strobing each completed interval and flagging a missing pulse with a timeout.
module pulse_period_meter
   import pulse_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned MAX_PERIOD  = DEF_MAX_PERIOD,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_pulse_in,
   output logic [CNT_W-1:0] o_period,
   output logic             o_period_valid,
   output logic             o_timeout,
   output logic             o_locked
);
   localparam logic [CNT_W-1:0] L_MAX = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);
   logic             w_edge;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_async (i_pulse_in),
      .o_edge  (w_edge)
   );
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         o_period       <= '0;
         o_period_valid <= 1'b0;
         o_timeout      <= 1'b0;
         o_locked       <= 1'b0;
      end else begin
         o_period_valid <= 1'b0;
         o_timeout      <= 1'b0;
         // disable overrides any edge arriving in the same cycle
         if (!i_en) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            o_locked <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: r_state <= ST_ARM;
               ST_ARM: begin
                  if (w_edge) begin
                     r_state <= ST_MEAS;
                     r_cnt   <= L_ONE;
                  end
               end
               ST_MEAS: begin
                  if (w_edge) begin
                     o_period       <= r_cnt;
                     o_period_valid <= 1'b1;
                     o_locked       <= 1'b1;
                     r_cnt          <= L_ONE;
                  end else if (r_cnt == L_MAX) begin
                     o_timeout <= 1'b1;
                     o_locked  <= 1'b0;
                     r_cnt     <= '0;
                     r_state   <= ST_ARM;
                  end else begin
                     r_cnt <= r_cnt + L_ONE;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: scoreboard bench; expected strobes are queued as pulses are driven
// and matched against period_valid / timeout as they appear.
module tb_pulse_period_meter;
   localparam int unsigned CNT_W = 27;
   localparam int unsigned MAXP  = 50;
   typedef struct packed {
      logic             is_to;
      logic [CNT_W-1:0] val;
   } exp_t;
   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             pulse_in;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             timeout;
   logic             locked;
   exp_t             sb[$];
   int               n_checks = 0;
   int               n_errors = 0;
   pulse_period_meter #(.CNT_W(CNT_W), .MAX_PERIOD(MAXP), .SYNC_STAGES(2)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_en           (en),
      .i_pulse_in     (pulse_in),
      .o_period       (period),
      .o_period_valid (period_valid),
      .o_timeout      (timeout),
      .o_locked       (locked)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic push_p(input int v);
      sb.push_back('{is_to: 1'b0, val: CNT_W'(v)});
   endtask
   task automatic push_to(input int v);
      sb.push_back('{is_to: 1'b1, val: CNT_W'(v)});
   endtask
   // rising edges every per cycles, each high for hi cycles; the first edge only arms
   task automatic train(input int n, input int per, input int hi, input bit expect_strobes);
      for (int i = 0; i < n; i++) begin
         pulse_in = 1'b1;
         if (expect_strobes && i > 0) push_p(per);
         repeat (hi) @(negedge clk);
         pulse_in = 1'b0;
         repeat (per - hi) @(negedge clk);
      end
   endtask
   always @(negedge clk) begin
      if (rst_n) begin
         if (period_valid && timeout) chk("valid_and_timeout", 1, 0);
         if (period_valid || timeout) begin
            if (sb.size() == 0) begin
               chk("unexpected_strobe", {30'd0, timeout, period_valid}, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("strobe_kind", {31'd0, timeout}, {31'd0, e.is_to});
               chk(e.is_to ? "timeout_period_held" : "period", {5'd0, period}, {5'd0, e.val});
               chk("locked_at_strobe", {31'd0, locked}, {31'd0, ~e.is_to});
            end
         end
      end
   end
   initial begin
      int n;
      rst_n = 1'b0;
      en = 1'b0;
      pulse_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_period", {5'd0, period}, 0);
      chk("rst_valid", {31'd0, period_valid}, 0);
      chk("rst_timeout", {31'd0, timeout}, 0);
      chk("rst_locked", {31'd0, locked}, 0);
      rst_n = 1'b1;
      en = 1'b1;
      repeat (3) @(negedge clk);
      // divider tick with MAX_COUNT=9
      train(6, 10, 1, 1'b1);
      chk("div_locked", {31'd0, locked}, 1);
      push_to(10);
      repeat (60) @(negedge clk);
      chk("div_unlocked_after_to", {31'd0, locked}, 0);
      // wide high levels: one edge each
      train(4, 20, 5, 1'b1);
      chk("wide_locked", {31'd0, locked}, 1);
      push_to(20);
      repeat (60) @(negedge clk);
      // single pulse then silence: timeout 50 cycles after arming edge
      push_to(20);
      pulse_in = 1'b1;
      n = 0;
      while (n < 200 && !timeout) begin
         @(negedge clk);
         n++;
         if (n == 1) pulse_in = 1'b0;
      end
      chk("timeout_latency", n, 53);
      chk("to_locked", {31'd0, locked}, 0);
      chk("to_period_held", {5'd0, period}, 20);
      repeat (5) @(negedge clk);
      train(2, 30, 1, 1'b1);
      chk("relock_30", {31'd0, locked}, 1);
      push_to(30);
      repeat (60) @(negedge clk);
      // interval exactly MAX_PERIOD: edge wins over timeout
      train(3, 50, 1, 1'b1);
      chk("max_locked", {31'd0, locked}, 1);
      push_to(50);
      repeat (60) @(negedge clk);
      // async reset mid-interval
      train(2, 25, 1, 1'b1);
      repeat (10) @(negedge clk);
      chk("pre_rst_queue", sb.size(), 0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_period", {5'd0, period}, 0);
      chk("arst_locked", {31'd0, locked}, 0);
      chk("arst_valid", {31'd0, period_valid}, 0);
      #13 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      train(3, 15, 1, 1'b1);
      push_to(15);
      repeat (60) @(negedge clk);
      // enable dropped between pulses
      train(2, 20, 1, 1'b1);
      en = 1'b0;
      repeat (2) @(negedge clk);
      chk("en_off_locked", {31'd0, locked}, 0);
      chk("en_off_period", {5'd0, period}, 20);
      train(3, 17, 1, 1'b0);
      chk("en_off_period_held", {5'd0, period}, 20);
      chk("en_off_locked_held", {31'd0, locked}, 0);
      en = 1'b1;
      repeat (3) @(negedge clk);
      train(3, 12, 1, 1'b1);
      chk("reen_locked", {31'd0, locked}, 1);
      push_to(12);
      repeat (60) @(negedge clk);
      chk("queue_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
